// File: rtl/score_bank_collector.sv
// Result collector for a scoring bank: per-lane holding registers, round-robin
// arbitration into an optional threshold filter and an output FIFO, plus max tracking.
module score_bank_collector #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 48,
    parameter int LANES       = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int LANE_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ld_query,
    input  logic [CNT_WIDTH-1:0]            q_count,
    input  logic                            filter_en,
    input  logic [SCORE_WIDTH-1:0]          threshold,
    input  logic [LANES*SCORE_WIDTH-1:0]    results,
    input  logic [LANES*ID_WIDTH-1:0]       ids,
    input  logic [LANES-1:0]                vld,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SCORE_WIDTH-1:0]          out_score,
    output logic [ID_WIDTH-1:0]             out_id,
    output logic [LANE_W-1:0]               out_lane,
    output logic [ID_WIDTH+SCORE_WIDTH-1:0] max,
    output logic                            vld_max,
    output logic                            busy,
    output logic                            overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = LANE_W + ID_WIDTH + SCORE_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t state;

    logic [SCORE_WIDTH-1:0] hold_score [LANES];
    logic [ID_WIDTH-1:0]    hold_id    [LANES];
    logic [LANES-1:0]       full;
    logic [LANE_W-1:0]      ptr;
    logic [CNT_WIDTH-1:0]   cnt, q_cnt, cnt_nxt;
    logic [SCORE_WIDTH-1:0] max_score;
    logic [ID_WIDTH-1:0]    max_id;

    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;
    logic [EW-1:0]          head;
    logic                   fifo_full, pop, push;

    logic                   gnt_any, grant, filtered;
    logic [LANE_W-1:0]      gnt_idx;
    logic [SCORE_WIDTH-1:0] gnt_score;
    logic [ID_WIDTH-1:0]    gnt_id;

    // Round-robin search starting at the lane after the last grant
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!gnt_any && full[(int'(ptr) + i) % LANES]) begin
                gnt_any = 1'b1;
                gnt_idx = LANE_W'((int'(ptr) + i) % LANES);
            end
        end
    end

    assign gnt_score = hold_score[gnt_idx];
    assign gnt_id    = hold_id[gnt_idx];
    assign filtered  = filter_en && (gnt_score < threshold);
    assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = (wr_ptr != rd_ptr);
    assign pop       = out_valid && out_ready;
    // Filtered entries are discarded, so only a real push can be held off by a full FIFO
    assign grant     = (state == RUN) && !ld_query && gnt_any && !(fifo_full && !pop && !filtered);
    assign push      = grant && !filtered;
    assign cnt_nxt   = cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            vld_max   <= 1'b0;
            q_cnt     <= '0;
            cnt       <= '0;
            ptr       <= '0;
            max_score <= '0;
            max_id    <= '0;
        end else begin
            vld_max <= 1'b0;
            if (ld_query) begin
                state     <= RUN;
                busy      <= 1'b1;
                q_cnt     <= q_count;
                cnt       <= '0;
                ptr       <= '0;
                max_score <= '0;
                max_id    <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    RUN: begin
                        if (grant) begin
                            cnt <= cnt_nxt;
                            ptr <= (gnt_idx == LANE_W'(LANES - 1)) ? '0 : gnt_idx + LANE_W'(1);
                            if (gnt_score > max_score) begin
                                max_score <= gnt_score;
                                max_id    <= gnt_id;
                            end
                        end
                        if (q_cnt == '0 || (grant && cnt_nxt == q_cnt)) begin
                            state   <= FINISH;
                            vld_max <= 1'b1;
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                hold_score[k] <= '0;
                hold_id[k]    <= '0;
            end
        end else if (ld_query) begin
            full     <= '0;
            overflow <= 1'b0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (grant && gnt_idx == LANE_W'(k))
                    full[k] <= 1'b0;
                if (state == RUN && vld[k]) begin
                    if (full[k] && !(grant && gnt_idx == LANE_W'(k))) begin
                        overflow <= 1'b1;
                    end else begin
                        full[k]       <= 1'b1;
                        hold_score[k] <= results[k*SCORE_WIDTH +: SCORE_WIDTH];
                        hold_id[k]    <= ids[k*ID_WIDTH +: ID_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {gnt_idx, gnt_id, gnt_score};
    end

    assign head      = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign out_score = head[SCORE_WIDTH-1:0];
    assign out_id    = head[SCORE_WIDTH +: ID_WIDTH];
    assign out_lane  = head[EW-1 -: LANE_W];
    assign max       = {max_id, max_score};
endmodule

// File: tb/tb_score_bank_collector.sv
// Bench for score_bank_collector: directed scenarios plus random traffic, compared
// every cycle against a queue-based transaction model of the collector.
module tb_score_bank_collector;
    localparam int SW = 12, IW = 48, L = 4, D = 16, CW = 16;

    logic clk = 0, rst = 1, ld_query = 0, filter_en = 0, out_ready = 1;
    logic [CW-1:0] q_count = '0;
    logic [SW-1:0] threshold = '0;
    logic [L*SW-1:0] results = '0;
    logic [L*IW-1:0] ids = '0;
    logic [L-1:0] vld = '0;
    logic out_valid, vld_max, busy, overflow;
    logic [SW-1:0] out_score;
    logic [IW-1:0] out_id;
    logic [1:0] out_lane;
    logic [IW+SW-1:0] max;

    score_bank_collector #(.SCORE_WIDTH(SW), .ID_WIDTH(IW), .LANES(L), .FIFO_DEPTH(D),
                           .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .ld_query(ld_query), .q_count(q_count), .filter_en(filter_en),
        .threshold(threshold), .results(results), .ids(ids), .vld(vld), .out_valid(out_valid),
        .out_ready(out_ready), .out_score(out_score), .out_id(out_id), .out_lane(out_lane),
        .max(max), .vld_max(vld_max), .busy(busy), .overflow(overflow));

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;

    // reference model: query bookkeeping, one-entry lane buffers, stream queue
    bit running, finishing, m_ovf;
    int cnt, q_cnt, rr;
    bit hf[L];
    logic [SW-1:0] hs[L];
    logic [IW-1:0] hi[L];
    logic [SW-1:0] mx_s;
    logic [IW-1:0] mx_id;
    logic [61:0] mq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        running = 0; finishing = 0; m_ovf = 0; cnt = 0; q_cnt = 0; rr = 0;
        mx_s = '0; mx_id = '0; mq.delete();
        for (int k = 0; k < L; k++) begin hf[k] = 0; hs[k] = '0; hi[k] = '0; end
    endtask

    task automatic model_step();
        bit pop, was_full, gr, filt;
        int g;
        logic [SW-1:0] gs;
        logic [IW-1:0] gi;
        pop = (mq.size() > 0) && out_ready;
        was_full = (mq.size() == D);
        if (pop) void'(mq.pop_front());
        gr = 0; g = 0; filt = 0; gs = '0; gi = '0;
        if (ld_query) begin
            q_cnt = int'(q_count); cnt = 0; mx_s = '0; mx_id = '0; m_ovf = 0; rr = 0;
            for (int k = 0; k < L; k++) hf[k] = 0;
            running = 1; finishing = 0;
        end else if (running) begin
            for (int i = 0; i < L; i++)
                if (!gr && hf[(rr + i) % L]) begin gr = 1; g = (rr + i) % L; end
            if (gr) begin
                gs = hs[g]; gi = hi[g];
                filt = filter_en && (gs < threshold);
                if (was_full && !pop && !filt) gr = 0;
            end
            if (gr) hf[g] = 0;
            for (int k = 0; k < L; k++)
                if (vld[k]) begin
                    if (hf[k]) m_ovf = 1;
                    else begin hf[k] = 1; hs[k] = results[k*SW +: SW]; hi[k] = ids[k*IW +: IW]; end
                end
            if (gr) begin
                cnt++;
                if (gs > mx_s) begin mx_s = gs; mx_id = gi; end
                rr = (g + 1) % L;
                if (!filt) mq.push_back({2'(g), gi, gs});
            end
            if (q_cnt == 0 || (gr && cnt == q_cnt)) begin running = 0; finishing = 1; end
        end else if (finishing) begin
            finishing = 0;
        end
    endtask

    task automatic check_outputs();
        logic [61:0] h;
        h = (mq.size() > 0) ? mq[0] : '0;
        chk("busy", busy, running || finishing);
        chk("vld_max", vld_max, finishing);
        chk("overflow", overflow, m_ovf);
        chk("max", max, {mx_id, mx_s});
        chk("out_valid", out_valid, mq.size() > 0);
        chk("out_score", out_score, h[11:0]);
        chk("out_id", out_id, h[59:12]);
        chk("out_lane", out_lane, h[61:60]);
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            check_outputs();
            ld_query = 0;
            vld = '0;
        end
    endtask

    task automatic strobe(input int k, input logic [SW-1:0] s, input logic [IW-1:0] id);
        vld[k] = 1'b1;
        results[k*SW +: SW] = s;
        ids[k*IW +: IW] = id;
    endtask

    task automatic query(input int n);
        ld_query = 1; q_count = CW'(n);
    endtask

    initial begin
        model_reset();
        #12 rst = 0;
        cyc(2);

        // four lanes at once, tie on 0x820 keeps lane 1
        query(4); cyc();
        strobe(0, 12'h810, 48'd1); strobe(1, 12'h820, 48'd2);
        strobe(2, 12'h805, 48'd3); strobe(3, 12'h820, 48'd4); cyc();
        cyc(8);
        chk("t1_max", max, {48'd2, 12'h820});

        // threshold filter
        filter_en = 1; threshold = 12'h808;
        query(3); cyc();
        strobe(0, 12'h800, 48'h11); strobe(1, 12'h810, 48'h12); strobe(2, 12'h807, 48'h13); cyc();
        cyc(6);
        chk("t2_max", max, {48'h12, 12'h810});
        filter_en = 0;

        // FIFO fill with consumer stalled, then drain
        out_ready = 0;
        query(100); cyc();
        for (int i = 0; i < D + 2; i++) begin
            strobe(0, 12'h900 + 12'(i), 48'(100 + i)); cyc(2);
        end
        chk("t3_overflow", overflow, 1'b1);
        chk("t3_valid", out_valid, 1'b1);
        out_ready = 1;
        cyc(24);

        // lane 1 back-to-back while lanes 0 and 2 are pending
        query(5); cyc();
        strobe(0, 12'h830, 48'h21); strobe(1, 12'h831, 48'h22); strobe(2, 12'h832, 48'h23); cyc();
        strobe(1, 12'h840, 48'h24); cyc();
        chk("t4_overflow", overflow, 1'b1);
        cyc(3);
        strobe(3, 12'h801, 48'h25); strobe(1, 12'h802, 48'h26); cyc();
        cyc(5);

        // empty query
        query(0); cyc(); cyc(); cyc();
        chk("t5_max", max, '0);

        // abort after 2 of 5, then asynchronous reset
        query(5); cyc();
        strobe(0, 12'h850, 48'h31); strobe(1, 12'h860, 48'h32); cyc(); cyc(2);
        query(5); cyc();
        chk("t6_restart_max", max, '0);
        cyc(3);
        out_ready = 0;
        strobe(2, 12'h870, 48'h33); cyc(); cyc(2);
        #2 rst = 1;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_max", max, '0);
        model_reset();
        #3 rst = 0;
        out_ready = 1;
        cyc(2);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 39) == 0) query($urandom_range(0, 12));
            for (int k = 0; k < L; k++)
                if ($urandom_range(0, 3) == 0)
                    strobe(k, 12'h7F0 + 12'($urandom_range(0, 63)), {16'h0, 32'($urandom)});
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) filter_en = ~filter_en;
            threshold = 12'h808;
            cyc();
        end
        out_ready = 1;
        cyc(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
